// File: rtl/doodle_jump_fsm_if.sv
// Doodle jump sequencer bus: player inputs in, one-hot state and counters out.
// The motion controller and the sequencer both connect through this bundle.
interface doodle_jump_fsm_if;
    logic        start;
    logic        land;
    logic [9:0]  ypos;
    logic        q_I;
    logic        q_Up;
    logic        q_Down;
    logic        q_Done;
    logic [7:0]  jump_cnt;
    logic [15:0] altitude;
    logic [7:0]  score;

    modport master (
        output start,
        output land,
        output ypos,
        input  q_I,
        input  q_Up,
        input  q_Down,
        input  q_Done,
        input  jump_cnt,
        input  altitude,
        input  score
    );

    modport slave (
        input  start,
        input  land,
        input  ypos,
        output q_I,
        output q_Up,
        output q_Down,
        output q_Done,
        output jump_cnt,
        output altitude,
        output score
    );
endinterface

// File: rtl/doodle_jump_fsm.sv
// Doodle jump/game-state sequencer: jump travel, apex/landing/fall-off,
// altitude and score, feeding one-hot states to the motion controller.
module doodle_jump_fsm #(
    parameter int STEP        = 2,
    parameter int JUMP_HEIGHT = 80,
    parameter int TOP_Y       = 60,
    parameter int BOTTOM_Y    = 505,
    parameter int SCORE_SHIFT = 3
) (
    input  logic               clk,
    input  logic               rst,
    doodle_jump_fsm_if.slave   dj
);

    if (JUMP_HEIGHT > 254 || JUMP_HEIGHT < 1 || STEP < 1) begin : g_bad_param
        $error("doodle_jump_fsm: JUMP_HEIGHT must be 1..254 and STEP >= 1");
    end

    localparam logic [8:0]  STEP9  = 9'(STEP);
    localparam logic [16:0] STEP17 = 17'(STEP);
    localparam logic [15:0] STEP16 = 16'(STEP);
    localparam logic [8:0]  JH9    = 9'(JUMP_HEIGHT);
    localparam logic [9:0]  TOP10  = 10'(TOP_Y);
    localparam logic [9:0]  BOT10  = 10'(BOTTOM_Y);

    // One-hot encoding so that any corrupted pattern is detectable.
    typedef enum logic [3:0] {
        S_INIT = 4'b0001,
        S_UP   = 4'b0010,
        S_DOWN = 4'b0100,
        S_DONE = 4'b1000
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  jump_cnt_q, jump_cnt_d;
    logic [15:0] alt_q, alt_d;
    logic [15:0] max_alt_q, max_alt_d;
    logic        start_q;

    logic        start_rise;
    logic [8:0]  jump_sum;
    logic [16:0] alt_sum;
    logic [15:0] alt_inc;
    logic [15:0] alt_dec;
    logic        apex;
    logic        ceiling;
    logic        fell_off;
    logic [15:0] score_full;

    assign start_rise = dj.start & ~start_q;
    assign jump_sum   = {1'b0, jump_cnt_q} + STEP9;
    assign alt_sum    = {1'b0, alt_q} + STEP17;
    assign alt_inc    = alt_sum[16] ? 16'hFFFF : alt_sum[15:0];
    assign alt_dec    = (alt_q < STEP16) ? 16'h0000 : (alt_q - STEP16);
    assign apex       = (jump_sum >= JH9);
    assign ceiling    = (dj.ypos <= TOP10);
    assign fell_off   = (dj.ypos >= BOT10);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_INIT;
            jump_cnt_q <= 8'd0;
            alt_q      <= 16'd0;
            max_alt_q  <= 16'd0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            jump_cnt_q <= jump_cnt_d;
            alt_q      <= alt_d;
            max_alt_q  <= max_alt_d;
            start_q    <= dj.start;
        end
    end

    always_comb begin
        state_d    = state_q;
        jump_cnt_d = jump_cnt_q;
        alt_d      = alt_q;
        max_alt_d  = max_alt_q;
        unique case (state_q)
            S_INIT: begin
                jump_cnt_d = 8'd0;
                alt_d      = 16'd0;
                max_alt_d  = 16'd0;
                if (start_rise) begin
                    state_d = S_UP;
                end
            end
            S_UP: begin
                jump_cnt_d = jump_sum[7:0];
                alt_d      = alt_inc;
                max_alt_d  = (alt_inc > max_alt_q) ? alt_inc : max_alt_q;
                if (apex || ceiling) begin
                    state_d = S_DOWN;
                end
            end
            S_DOWN: begin
                // Landing wins over fall-off when both happen together.
                if (dj.land) begin
                    state_d    = S_UP;
                    jump_cnt_d = 8'd0;
                end else if (fell_off) begin
                    state_d = S_DONE;
                end else begin
                    alt_d = alt_dec;
                end
            end
            S_DONE: begin
                if (start_rise) begin
                    state_d    = S_INIT;
                    jump_cnt_d = 8'd0;
                    alt_d      = 16'd0;
                    max_alt_d  = 16'd0;
                end
            end
            default: begin
                state_d    = S_INIT;
                jump_cnt_d = 8'd0;
                alt_d      = 16'd0;
                max_alt_d  = 16'd0;
            end
        endcase
    end

    assign score_full = max_alt_q >> SCORE_SHIFT;

    assign dj.q_I      = (state_q == S_INIT);
    assign dj.q_Up     = (state_q == S_UP);
    assign dj.q_Down   = (state_q == S_DOWN);
    assign dj.q_Done   = (state_q == S_DONE);
    assign dj.jump_cnt = jump_cnt_q;
    assign dj.altitude = alt_q;
    assign dj.score    = (|score_full[15:8]) ? 8'hFF : score_full[7:0];

endmodule
